// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: one main entry plus one skid entry, valid/ready on both sides,
// with stall/flush controls and saturating stall and flush event counters.
module pipe_stage_skid #(
    parameter int DATA_W         = 257,
    parameter bit ZERO_ON_BUBBLE = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              r_main_valid;
    logic              r_skid_valid;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_out_valid;
    logic              w_transfer;
    logic              w_accept;
    logic              w_stall_evt;
    logic              w_main_valid_nxt;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;

    assign w_out_valid = r_main_valid & ~stall;
    assign w_transfer  = w_out_valid & out_ready;
    assign w_accept    = in_valid & r_in_ready;
    assign w_stall_evt = r_main_valid & (stall | ~out_ready) & ~flush;

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_main_data_nxt  = r_main_data;
        w_skid_data_nxt  = r_skid_data;
        if (flush) begin
            // A beat accepted this cycle is dropped along with the held ones.
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
            if (ZERO_ON_BUBBLE) begin
                w_main_data_nxt = '0;
                w_skid_data_nxt = '0;
            end
        end else if (w_transfer) begin
            if (r_skid_valid) begin
                w_main_data_nxt  = r_skid_data;
                w_skid_valid_nxt = 1'b0;
            end else if (w_accept) begin
                w_main_data_nxt = in_data;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            if (r_main_valid) begin
                w_skid_data_nxt  = in_data;
                w_skid_valid_nxt = 1'b1;
            end else begin
                w_main_data_nxt  = in_data;
                w_main_valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_main_data  <= '0;
            r_skid_data  <= '0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_skid_data  <= w_skid_data_nxt;
            if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (flush && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main_data;
    assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations; a second narrow instance exercises counter saturation.
module tb_pipe_stage_skid;

    localparam int DATA_W = 257;
    localparam int CNT_W  = 16;
    localparam int SAT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              stall;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;

    logic              in_ready, out_valid;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    logic              s_in_ready, s_out_valid;
    logic [7:0]        s_out_data;
    logic [1:0]        s_occupancy;
    logic [SAT_W-1:0]  s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DATA_W), .ZERO_ON_BUBBLE(1'b1), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_skid #(.DATA_W(8), .ZERO_ON_BUBBLE(1'b0), .CNT_W(SAT_W)) u_sat (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data[7:0]),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: the stage is a FIFO of depth two; counters are plain ints saturated on compare.
    logic [DATA_W-1:0] mq[$];
    int  m_stall = 0;
    int  m_flush = 0;
    bit  m_init  = 0;
    bit  m_xfer, m_acc;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_stall = 0;
            m_flush = 0;
            m_init  = 1;
        end else if (m_init) begin
            m_xfer = (mq.size() > 0) && !stall && out_ready;
            m_acc  = in_valid && (mq.size() < 2);
            if ((mq.size() > 0) && (stall || !out_ready) && !flush) m_stall++;
            if (flush) begin
                mq.delete();
                m_flush++;
            end else begin
                if (m_xfer) void'(mq.pop_front());
                if (m_acc) mq.push_back(in_data);
            end
        end
    end

    function automatic int sat(input int v, input int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    always @(negedge clk) begin
        if (m_init) begin
            chk("out_valid", DATA_W'(out_valid), DATA_W'((mq.size() > 0) && !stall));
            chk("in_ready", DATA_W'(in_ready), DATA_W'(mq.size() < 2));
            chk("occupancy", DATA_W'(occupancy), DATA_W'(mq.size()));
            chk("stall_cnt", DATA_W'(stall_cnt), DATA_W'(sat(m_stall, CNT_W)));
            chk("flush_cnt", DATA_W'(flush_cnt), DATA_W'(sat(m_flush, CNT_W)));
            if (mq.size() > 0) chk("out_data", out_data, mq[0]);
            chk("sat_occupancy", DATA_W'(s_occupancy), DATA_W'(mq.size()));
            chk("sat_out_valid", DATA_W'(s_out_valid), DATA_W'((mq.size() > 0) && !stall));
            chk("sat_stall_cnt", DATA_W'(s_stall_cnt), DATA_W'(sat(m_stall, SAT_W)));
            chk("sat_flush_cnt", DATA_W'(s_flush_cnt), DATA_W'(sat(m_flush, SAT_W)));
            if (mq.size() > 0) begin
                logic [DATA_W-1:0] front;
                front = mq[0];
                chk("sat_out_data", DATA_W'(s_out_data), DATA_W'(front[7:0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1; flush = 0; stall = 0; in_valid = 0; out_ready = 0; in_data = '0;
        step();
        rst = 0;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        d = '0;
        for (int k = 0; k < 9; k++) d = {d[DATA_W-33:0], 32'($urandom())};
        return d;
    endfunction

    initial begin
        rst = 1; flush = 0; stall = 0; in_valid = 0; out_ready = 0; in_data = '0;
        step();
        step();
        rst = 0;
        @(negedge clk);
        chk("rst_in_ready", DATA_W'(in_ready), DATA_W'(1));
        chk("rst_out_data", out_data, '0);
        chk("rst_occ", DATA_W'(occupancy), DATA_W'(0));

        // Pass-through at full rate.
        do_reset();
        in_valid = 1; out_ready = 1; in_data = DATA_W'(1);
        step(); in_data = DATA_W'(2);
        @(negedge clk); chk("pt_data1", out_data, DATA_W'(1)); chk("pt_occ1", DATA_W'(occupancy), DATA_W'(1));
        step(); in_data = DATA_W'(3);
        @(negedge clk); chk("pt_data2", out_data, DATA_W'(2)); chk("pt_occ2", DATA_W'(occupancy), DATA_W'(1));
        step(); in_valid = 0;
        @(negedge clk); chk("pt_data3", out_data, DATA_W'(3)); chk("pt_stall", DATA_W'(stall_cnt), DATA_W'(0));
        step();

        // Backpressure fills main then skid; third beat waits.
        do_reset();
        in_valid = 1; out_ready = 0; in_data = DATA_W'('hA);
        step(); in_data = DATA_W'('hB);
        step(); in_data = DATA_W'('hC);
        @(negedge clk);
        chk("bp_occ", DATA_W'(occupancy), DATA_W'(2));
        chk("bp_in_ready", DATA_W'(in_ready), DATA_W'(0));
        chk("bp_data_a", out_data, DATA_W'('hA));
        chk("bp_stall1", DATA_W'(stall_cnt), DATA_W'(1));
        step();
        @(negedge clk); chk("bp_stall2", DATA_W'(stall_cnt), DATA_W'(2));
        step(); out_ready = 1;
        @(negedge clk); chk("bp_out_a", out_data, DATA_W'('hA)); chk("bp_stall3", DATA_W'(stall_cnt), DATA_W'(3));
        step();
        @(negedge clk); chk("bp_out_b", out_data, DATA_W'('hB)); chk("bp_rdy_back", DATA_W'(in_ready), DATA_W'(1));
        step(); in_valid = 0;
        @(negedge clk); chk("bp_out_c", out_data, DATA_W'('hC));
        step();

        // External stall holds a beat for three cycles.
        do_reset();
        in_valid = 1; out_ready = 1; in_data = DATA_W'('h55);
        step(); in_valid = 0; stall = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("st_out_valid", DATA_W'(out_valid), DATA_W'(0));
            step();
        end
        stall = 0;
        @(negedge clk);
        chk("st_release", DATA_W'(out_valid), DATA_W'(1));
        chk("st_data", out_data, DATA_W'('h55));
        chk("st_cnt", DATA_W'(stall_cnt), DATA_W'(3));
        step();

        // Flush of a full stage with a beat arriving.
        do_reset();
        in_valid = 1; out_ready = 0; in_data = DATA_W'('h11);
        step(); in_data = DATA_W'('h22);
        step(); in_data = DATA_W'('h33); flush = 1;
        step(); flush = 0; in_valid = 0; out_ready = 1;
        @(negedge clk);
        chk("fl_occ", DATA_W'(occupancy), DATA_W'(0));
        chk("fl_in_ready", DATA_W'(in_ready), DATA_W'(1));
        chk("fl_data_zero", out_data, '0);
        chk("fl_sat_retain", DATA_W'(s_out_data), DATA_W'('h11));
        chk("fl_cnt", DATA_W'(flush_cnt), DATA_W'(1));
        step();
        @(negedge clk); chk("fl_no_beat", DATA_W'(out_valid), DATA_W'(0));

        // Saturation on the narrow counters.
        do_reset();
        in_valid = 1; out_ready = 0; in_data = DATA_W'('h7);
        step(); in_valid = 0;
        for (int k = 0; k < 5; k++) step();
        @(negedge clk);
        chk("sat_stall", DATA_W'(s_stall_cnt), DATA_W'(3));
        chk("wide_stall", DATA_W'(stall_cnt), DATA_W'(5));
        for (int k = 0; k < 5; k++) begin
            step(); flush = 1;
        end
        step(); flush = 0;
        @(negedge clk); chk("sat_flush", DATA_W'(s_flush_cnt), DATA_W'(3));

        // Reset while full.
        do_reset();
        in_valid = 1; out_ready = 0; in_data = DATA_W'('h91);
        step(); in_data = DATA_W'('h92);
        step(); rst = 1;
        step(); rst = 0; in_valid = 0;
        @(posedge clk); #1; rst = 1;
        @(negedge clk);
        chk("rr_occ", DATA_W'(occupancy), DATA_W'(0));
        chk("rr_out_valid", DATA_W'(out_valid), DATA_W'(0));
        chk("rr_in_ready", DATA_W'(in_ready), DATA_W'(1));
        chk("rr_out_data", out_data, '0);
        chk("rr_stall_cnt", DATA_W'(stall_cnt), DATA_W'(0));
        step(); rst = 0;

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            step();
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            stall     = ($urandom_range(0, 99) < 15);
            flush     = ($urandom_range(0, 99) < 3);
            rst       = ($urandom_range(0, 999) < 5);
            in_data   = rand_data();
        end
        step();
        rst = 0; flush = 0; stall = 0; in_valid = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
